// File: rtl/audio_dac_serializer.sv
// Stereo sample FIFO feeding a left-justified, MSB-first serial DAC output.
// BCLK and LRCK come from the CODEC and are resynchronized onto CLOCK_50.
module audio_dac_serializer #(
    parameter int DATA_W     = 24,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          CLOCK_50,
    input  logic                          reset_n,
    input  logic                          write,
    input  logic [DATA_W-1:0]             writedata_left,
    input  logic [DATA_W-1:0]             writedata_right,
    output logic                          write_ready,
    input  logic                          AUD_BCLK,
    input  logic                          AUD_DACLRCK,
    output logic                          AUD_DACDAT,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          underflow,
    output logic                          overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int NW = AW + 1;
    localparam int CW = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {SYNC, LEFT, RIGHT} state_t;

    state_t              state;
    logic [1:0]          bclk_sync;
    logic [1:0]          lrck_sync;
    logic                bclk_prev;
    logic                lrck_sampled;
    logic                bclk_fall;
    logic                lr_rise;
    logic                lr_fall;

    logic [2*DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW:0]         wr_ptr;
    logic [AW:0]         rd_ptr;
    logic                fifo_empty;
    logic                push;
    logic                pop;
    logic [2*DATA_W-1:0] head;

    logic [DATA_W-1:0]   shreg;
    logic [DATA_W-1:0]   right_hold;
    logic [DATA_W-1:0]   load_word;
    logic [CW-1:0]       bit_cnt;

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            bclk_sync    <= '0;
            lrck_sync    <= '0;
            bclk_prev    <= 1'b0;
            lrck_sampled <= 1'b0;
        end else begin
            bclk_sync <= {bclk_sync[0], AUD_BCLK};
            lrck_sync <= {lrck_sync[0], AUD_DACLRCK};
            bclk_prev <= bclk_sync[1];
            if (bclk_fall)
                lrck_sampled <= lrck_sync[1];
        end
    end

    // LRCK only matters at BCLK falling edges, where the CODEC changes it.
    assign bclk_fall = bclk_prev & ~bclk_sync[1];
    assign lr_rise   = bclk_fall &  lrck_sync[1] & ~lrck_sampled;
    assign lr_fall   = bclk_fall & ~lrck_sync[1] &  lrck_sampled;

    assign fifo_empty  = (wr_ptr == rd_ptr);
    assign write_ready = (fifo_count != NW'(FIFO_DEPTH));
    assign push        = write & write_ready;
    assign pop         = lr_rise & ~fifo_empty;
    assign head        = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge CLOCK_50) begin
        if (push)
            mem[wr_ptr[AW-1:0]] <= {writedata_left, writedata_right};
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + NW'(1);
            if (pop)
                rd_ptr <= rd_ptr + NW'(1);
            fifo_count <= fifo_count + NW'(push) - NW'(pop);
            if (write && !write_ready)
                overflow <= 1'b1;
        end
    end

    // An empty FIFO at frame start sends silence on both channels.
    always_comb begin
        load_word = right_hold;
        if (lr_rise)
            load_word = fifo_empty ? '0 : head[2*DATA_W-1:DATA_W];
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state      <= SYNC;
            AUD_DACDAT <= 1'b0;
            shreg      <= '0;
            right_hold <= '0;
            bit_cnt    <= '0;
            underflow  <= 1'b0;
        end else begin
            underflow <= 1'b0;
            if (lr_rise) begin
                state      <= LEFT;
                right_hold <= fifo_empty ? '0 : head[DATA_W-1:0];
                underflow  <= fifo_empty;
                AUD_DACDAT <= load_word[DATA_W-1];
                shreg      <= {load_word[DATA_W-2:0], 1'b0};
                bit_cnt    <= CW'(DATA_W - 1);
            end else if (lr_fall && state == LEFT) begin
                state      <= RIGHT;
                AUD_DACDAT <= load_word[DATA_W-1];
                shreg      <= {load_word[DATA_W-2:0], 1'b0};
                bit_cnt    <= CW'(DATA_W - 1);
            end else if (bclk_fall && state != SYNC) begin
                // shreg holds the bits still to be sent, next one in the MSB
                if (bit_cnt != '0) begin
                    AUD_DACDAT <= shreg[DATA_W-1];
                    shreg      <= {shreg[DATA_W-2:0], 1'b0};
                    bit_cnt    <= bit_cnt - CW'(1);
                end else begin
                    AUD_DACDAT <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_audio_dac_serializer.sv
// Directed bench for audio_dac_serializer: drives CODEC BCLK/LRCK at 64 BCLK
// per frame (8 CLOCK_50 cycles per BCLK) and reassembles the serial words.
module tb_audio_dac_serializer;

    logic        CLOCK_50 = 1'b0;
    logic        reset_n;
    logic        write;
    logic [23:0] writedata_left;
    logic [23:0] writedata_right;
    logic        write_ready;
    logic        AUD_BCLK;
    logic        AUD_DACLRCK;
    logic        AUD_DACDAT;
    logic [3:0]  fifo_count;
    logic        underflow;
    logic        overflow;

    int          checks_total  = 0;
    int          checks_passed = 0;
    int          checks_failed = 0;
    int          uf_count      = 0;
    int          uf_before;
    logic [3:0]  mid_count;
    logic [3:0]  rise_count;
    logic [31:0] left_bits;
    logic [31:0] right_bits;
    logic [31:0] acc;
    logic        b;

    audio_dac_serializer #(.DATA_W(24), .FIFO_DEPTH(8)) dut (
        .CLOCK_50        (CLOCK_50),
        .reset_n         (reset_n),
        .write           (write),
        .writedata_left  (writedata_left),
        .writedata_right (writedata_right),
        .write_ready     (write_ready),
        .AUD_BCLK        (AUD_BCLK),
        .AUD_DACLRCK     (AUD_DACLRCK),
        .AUD_DACDAT      (AUD_DACDAT),
        .fifo_count      (fifo_count),
        .underflow       (underflow),
        .overflow        (overflow)
    );

    initial forever #10 CLOCK_50 = ~CLOCK_50;

    always @(posedge CLOCK_50) begin
        if (underflow)
            uf_count <= uf_count + 1;
    end

    task automatic check_output(input string tag, input logic [63:0] observed,
                                input logic [63:0] expected);
        checks_total++;
        assert (observed === expected) checks_passed++;
        else begin
            checks_failed++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic apply_stimulus(input logic [23:0] l, input logic [23:0] r);
        @(negedge CLOCK_50);
        writedata_left  = l;
        writedata_right = r;
        write           = 1'b1;
        @(negedge CLOCK_50);
        write = 1'b0;
    endtask

    // One BCLK period; an optional push lands on the same cycle as a frame-start pop.
    task automatic bclk_bit(input logic lr, input bit push_now, output logic bit_out);
        @(negedge CLOCK_50);
        AUD_BCLK    = 1'b0;
        AUD_DACLRCK = lr;
        repeat (2) @(negedge CLOCK_50);
        if (push_now)
            write = 1'b1;
        @(negedge CLOCK_50);
        write     = 1'b0;
        mid_count = fifo_count;
        @(negedge CLOCK_50);
        AUD_BCLK = 1'b1;
        repeat (3) @(negedge CLOCK_50);
        bit_out = AUD_DACDAT;
    endtask

    task automatic run_frame(input bit push_at_rise);
        logic bo;
        for (int i = 0; i < 64; i++) begin
            bclk_bit(i < 32, push_at_rise && i == 0, bo);
            if (i == 0)
                rise_count = mid_count;
            if (i < 32)
                left_bits = {left_bits[30:0], bo};
            else
                right_bits = {right_bits[30:0], bo};
        end
    endtask

    task automatic check_frame(input string tag, input logic [23:0] l, input logic [23:0] r);
        run_frame(1'b0);
        check_output({tag, "_left"},  left_bits,  {l, 8'h00});
        check_output({tag, "_right"}, right_bits, {r, 8'h00});
    endtask

    initial begin
        logic [23:0] full_l [8];
        logic [23:0] full_r [8];
        logic [23:0] m0;
        logic [10:0] head_bits;

        reset_n         = 1'b0;
        write           = 1'b0;
        writedata_left  = '0;
        writedata_right = '0;
        AUD_BCLK        = 1'b1;
        AUD_DACLRCK     = 1'b0;

        // Reset held with the CODEC clocks running
        acc = '0;
        for (int i = 0; i < 8; i++) begin
            bclk_bit((i % 4) < 2, 1'b0, b);
            acc = acc | {31'd0, b};
        end
        check_output("reset_dacdat", acc, 0);
        check_output("reset_write_ready", write_ready, 1);
        check_output("reset_fifo_count", fifo_count, 0);
        check_output("reset_underflow", underflow, 0);
        check_output("reset_overflow", overflow, 0);

        @(negedge CLOCK_50);
        reset_n = 1'b1;
        acc = '0;
        for (int i = 0; i < 8; i++) begin
            bclk_bit(1'b0, 1'b0, b);
            acc = acc | {31'd0, b};
        end
        check_output("idle_dacdat", acc, 0);

        // Single pair
        apply_stimulus(24'hA5A5A5, 24'h3C3C3C);
        check_output("single_count_push", fifo_count, 1);
        check_frame("single", 24'hA5A5A5, 24'h3C3C3C);
        check_output("single_count_after_pop", rise_count, 0);

        // Fill with BCLK parked high, then one extra write
        for (int i = 0; i < 8; i++) begin
            full_l[i] = 24'h111111 * (i + 1);
            full_r[i] = full_l[i] ^ 24'hF0F0F0;
        end
        for (int i = 0; i < 7; i++)
            apply_stimulus(full_l[i], full_r[i]);
        check_output("full_ready_at_7", write_ready, 1);
        apply_stimulus(full_l[7], full_r[7]);
        check_output("full_ready_at_8", write_ready, 0);
        check_output("full_count", fifo_count, 8);
        check_output("overflow_before", overflow, 0);
        apply_stimulus(24'hDEAD00, 24'hBEEF00);
        check_output("overflow_set", overflow, 1);
        check_output("overflow_count", fifo_count, 8);
        for (int i = 0; i < 8; i++)
            check_frame($sformatf("full%0d", i), full_l[i], full_r[i]);
        check_output("full_drained", fifo_count, 0);
        check_output("overflow_sticky", overflow, 1);

        // Underflow frame followed by a late push
        uf_before = uf_count;
        check_frame("underflow", 24'h000000, 24'h000000);
        check_output("underflow_pulses", uf_count - uf_before, 1);
        apply_stimulus(24'h7FFFFF, 24'h800000);
        check_frame("after_underflow", 24'h7FFFFF, 24'h800000);
        check_output("underflow_no_repeat", uf_count - uf_before, 1);

        // Push coinciding with a frame-start pop at count 3
        apply_stimulus(24'h123456, 24'h654321);
        apply_stimulus(24'hABCDEF, 24'hFEDCBA);
        apply_stimulus(24'h000001, 24'h800001);
        check_output("simul_count_before", fifo_count, 3);
        writedata_left  = 24'hC0FFEE;
        writedata_right = 24'h0BADF0;
        run_frame(1'b1);
        check_output("simul_count_same", rise_count, 3);
        check_output("simul0_left", left_bits, {24'h123456, 8'h00});
        check_output("simul0_right", right_bits, {24'h654321, 8'h00});
        check_frame("simul1", 24'hABCDEF, 24'hFEDCBA);
        check_frame("simul2", 24'h000001, 24'h800001);
        check_frame("simul3", 24'hC0FFEE, 24'h0BADF0);
        check_output("simul_drained", fifo_count, 0);

        // Reset during bit 10 of a left word
        m0 = 24'h9E3779;
        apply_stimulus(m0, 24'h111000);
        apply_stimulus(24'h222333, 24'h444555);
        for (int i = 0; i < 11; i++) begin
            bclk_bit(1'b1, 1'b0, b);
            head_bits = {head_bits[9:0], b};
        end
        check_output("midreset_head_bits", head_bits, m0[23:13]);
        @(negedge CLOCK_50);
        reset_n = 1'b0;
        #1;
        check_output("midreset_dacdat", AUD_DACDAT, 0);
        check_output("midreset_count", fifo_count, 0);
        check_output("midreset_ready", write_ready, 1);
        check_output("midreset_overflow", overflow, 0);
        acc = '0;
        for (int i = 11; i < 64; i++) begin
            bclk_bit(i < 32, 1'b0, b);
            acc = acc | {31'd0, b};
            if (i == 32)
                reset_n = 1'b1;
        end
        check_output("midreset_silent", acc, 0);
        apply_stimulus(24'h5A5A5A, 24'hC3C3C3);
        check_frame("post_reset", 24'h5A5A5A, 24'hC3C3C3);
        check_output("post_reset_count", fifo_count, 0);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
